// File: rtl/asi_pkg.sv
// ---------------------------------------------------------------------------------------------
// asi_pkg: shared definitions for the ASI Manchester physical layer.
//   ASI_MASTER_LEN / ASI_SLAVE_LEN : payload lengths of master requests / slave responses
//   tx_state_e                     : transmitter FSM state
//   man_enc(b)                     : Manchester half-bit pair, [1] is sent first
//   parity(vec, len, even)         : parity bit over vec[len-1:0]
// ---------------------------------------------------------------------------------------------
package asi_pkg;

   localparam int unsigned ASI_MASTER_LEN = 11;
   localparam int unsigned ASI_SLAVE_LEN  = 4;

   // Widest payload the parity helper can cover.
   localparam int unsigned PAR_W = 32;

   typedef enum logic [1:0] {
      StIdle,
      StSend,
      StGap
   } tx_state_e;

   // A '1' is low-then-high, a '0' is high-then-low.
   function automatic logic [1:0] man_enc(input logic b);
      return {~b, b};
   endfunction

   // XOR of the low len bits; inverted for odd parity.
   function automatic logic parity(input logic [PAR_W-1:0] vec, input int unsigned len,
                                   input logic even);
      logic p;
      p = 1'b0;
      for (int unsigned i = 0; i < PAR_W; i++) begin
         if (i < len) p = p ^ vec[i];
      end
      return even ? p : ~p;
   endfunction

endpackage

// File: rtl/man_halfbit_tick.sv
// ---------------------------------------------------------------------------------------------
// man_halfbit_tick: emits a one-cycle tick every CLK_DIV enabled clock cycles.
//   clk_in : system clock
//   rst    : asynchronous active-low reset
//   clr    : restart the count (takes priority over en)
//   en     : count enable
//   tick   : high in the last cycle of each CLK_DIV-cycle period
// ---------------------------------------------------------------------------------------------
module man_halfbit_tick #(
   parameter int unsigned CLK_DIV = 150
) (
   input  logic clk_in,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int unsigned     CNT_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (en) begin
         cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      end
   end

   assign tick = en && !clr && (cnt_q == CNT_LAST);

endmodule

// File: rtl/man_coding_tx.sv
// ---------------------------------------------------------------------------------------------
// man_coding_tx: Manchester line transmitter for the ASI physical layer.
// Frame = {ST=0, payload MSB-first, PB, EB=1}; each bit is sent as two CLK_DIV-cycle
// half-bits (~b then b), followed by an idle gap of GAP_BITS bit-times.
//   clk_in   : system clock
//   rst      : asynchronous active-low reset
//   tx_valid : frame request present
//   tx_ready : request can be accepted (registered)
//   tx_data  : payload, first bit sent is tx_data[tx_len-1]
//   tx_len   : payload length, clamped to PAYLOAD_MAX
//   busy     : frame or gap in progress
//   done     : one-cycle pulse at frame end
//   code     : Manchester line output (registered)
// ---------------------------------------------------------------------------------------------
module man_coding_tx
   import asi_pkg::*;
#(
   parameter int unsigned CLK_DIV     = 150,
   parameter int unsigned PAYLOAD_MAX = 11,
   parameter int unsigned LEN_W       = 4,
   parameter int unsigned GAP_BITS    = 3,
   parameter int unsigned PARITY_EVEN = 1,
   parameter int unsigned IDLE_LEVEL  = 1
) (
   input  logic                   clk_in,
   input  logic                   rst,
   input  logic                   tx_valid,
   output logic                   tx_ready,
   input  logic [PAYLOAD_MAX-1:0] tx_data,
   input  logic [LEN_W-1:0]       tx_len,
   output logic                   busy,
   output logic                   done,
   output logic                   code
);

   localparam int unsigned FRAME_W = PAYLOAD_MAX + 3;
   localparam int unsigned HB_MAX  = (FRAME_W > GAP_BITS) ? 2 * FRAME_W : 2 * GAP_BITS;
   localparam int unsigned HB_W    = $clog2(HB_MAX);

   localparam logic             IDLE_L = (IDLE_LEVEL != 0);
   localparam logic             EVEN_L = (PARITY_EVEN != 0);
   localparam logic [LEN_W-1:0] PMAX_L = LEN_W'(PAYLOAD_MAX);
   localparam logic [HB_W-1:0]  GAP_HB = (GAP_BITS > 0) ? HB_W'(2 * GAP_BITS - 1) : '0;

   tx_state_e          state_q;
   logic [FRAME_W-1:0] frame_q;  // MSB is the bit currently on the line
   logic [HB_W-1:0]    hb_q;     // half-bits remaining after the current one

   logic                   accept;
   logic                   tick;
   logic [LEN_W-1:0]       len_c;
   logic [LEN_W-1:0]       shamt;
   logic [PAYLOAD_MAX-1:0] pay_al;
   logic                   pb;
   logic [FRAME_W-1:0]     frame_ld;
   logic [HB_W-1:0]        hb_ld;
   logic [1:0]             enc_st;
   logic [1:0]             enc_cur;
   logic [1:0]             enc_nxt;

   assign accept = tx_valid && tx_ready;

   // Left-justify the payload so bits above len-1 fall off, then drop PB/EB right after it.
   assign len_c    = (tx_len > PMAX_L) ? PMAX_L : tx_len;
   assign shamt    = PMAX_L - len_c;
   assign pay_al   = tx_data << shamt;
   assign pb       = parity(PAR_W'(tx_data), 32'(len_c), EVEN_L);
   assign frame_ld = {1'b0, pay_al, 2'b00} | (FRAME_W'({pb, 1'b1}) << shamt);

   // 2N half-bits with N = len + 3; count down to zero so hb_q[0] marks the first half.
   assign hb_ld = HB_W'({len_c, 1'b0}) + HB_W'(5);

   assign enc_st  = man_enc(1'b0);
   assign enc_cur = man_enc(frame_q[FRAME_W-1]);
   assign enc_nxt = man_enc(frame_q[FRAME_W-2]);

   man_halfbit_tick #(
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .clk_in (clk_in),
      .rst    (rst),
      .clr    (accept),
      .en     (state_q != StIdle),
      .tick   (tick)
   );

   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         state_q  <= StIdle;
         frame_q  <= '0;
         hb_q     <= '0;
         code     <= IDLE_L;
         tx_ready <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  frame_q  <= frame_ld;
                  hb_q     <= hb_ld;
                  code     <= enc_st[1];
                  tx_ready <= 1'b0;
                  busy     <= 1'b1;
                  state_q  <= StSend;
               end else begin
                  tx_ready <= 1'b1;
               end
            end
            StSend: begin
               if (tick) begin
                  if (hb_q[0]) begin
                     code <= enc_cur[0];
                     hb_q <= hb_q - 1'b1;
                  end else if (hb_q != '0) begin
                     frame_q <= frame_q << 1;
                     code    <= enc_nxt[1];
                     hb_q    <= hb_q - 1'b1;
                  end else begin
                     done <= 1'b1;
                     code <= IDLE_L;
                     if (GAP_BITS > 0) begin
                        hb_q    <= GAP_HB;
                        state_q <= StGap;
                     end else begin
                        busy     <= 1'b0;
                        tx_ready <= 1'b1;
                        state_q  <= StIdle;
                     end
                  end
               end
            end
            StGap: begin
               if (tick) begin
                  if (hb_q == '0) begin
                     busy     <= 1'b0;
                     tx_ready <= 1'b1;
                     state_q  <= StIdle;
                  end else begin
                     hb_q <= hb_q - 1'b1;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_man_coding_tx.sv
// ---------------------------------------------------------------------------------------------
// tb_man_coding_tx: self-checking bench for man_coding_tx (CLK_DIV=4, GAP_BITS=3, even parity,
// idle high). A frame-level reference model predicts code/busy/done/tx_ready every cycle;
// directed scenarios pin waveforms, latencies and spacing with hand-computed literals.
// ---------------------------------------------------------------------------------------------
module tb_man_coding_tx;

   localparam int CLK_DIV  = 4;
   localparam int GAP_BITS = 3;
   localparam int GAPC     = 2 * GAP_BITS * CLK_DIV;

   logic        clk_in   = 1'b0;
   logic        rst      = 1'b1;
   logic        tx_valid = 1'b0;
   logic [10:0] tx_data  = '0;
   logic [3:0]  tx_len   = '0;
   logic        tx_ready;
   logic        busy;
   logic        done;
   logic        code;

   int n_tests = 0;
   int n_fail  = 0;
   bit run_chk = 1'b0;
   int d_acc   = 0;
   bit prev_b  = 1'b0;

   man_coding_tx #(
      .CLK_DIV     (CLK_DIV),
      .PAYLOAD_MAX (11),
      .LEN_W       (4),
      .GAP_BITS    (GAP_BITS),
      .PARITY_EVEN (1),
      .IDLE_LEVEL  (1)
   ) dut (
      .clk_in   (clk_in),
      .rst      (rst),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .tx_data  (tx_data),
      .tx_len   (tx_len),
      .busy     (busy),
      .done     (done),
      .code     (code)
   );

   initial forever #5 clk_in = ~clk_in;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   bit m_ready = 1'b0;
   bit m_busy  = 1'b0;
   bit m_done  = 1'b0;
   bit m_code  = 1'b1;
   int m_t     = 0;
   int m_L     = 0;
   bit m_hb[$];

   function automatic void model_load(input logic [10:0] d, input logic [3:0] l);
      int len;
      int ones;
      bit bits[$];
      len  = (l > 4'd11) ? 11 : int'(l);
      ones = 0;
      bits.push_back(1'b0);
      for (int i = len - 1; i >= 0; i--) begin
         bits.push_back(d[i]);
         ones += int'(d[i]);
      end
      bits.push_back((ones % 2) != 0);
      bits.push_back(1'b1);
      m_hb.delete();
      foreach (bits[i]) begin
         m_hb.push_back(!bits[i]);
         m_hb.push_back(bits[i]);
      end
      m_L = m_hb.size() * CLK_DIV;
   endfunction

   initial forever begin
      @(posedge clk_in or negedge rst);
      if (!rst) begin
         m_ready = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_code = 1'b1; m_t = 0;
      end else if (!m_busy) begin
         m_done = 1'b0;
         if (tx_valid && m_ready) begin
            model_load(tx_data, tx_len);
            m_busy = 1'b1; m_ready = 1'b0; m_t = 1; m_code = m_hb[0];
         end else begin
            m_ready = 1'b1; m_code = 1'b1;
         end
      end else begin
         m_t++;
         m_code = (m_t <= m_L) ? m_hb[(m_t - 1) / CLK_DIV] : 1'b1;
         m_done = (m_t == m_L + 1);
         if (m_t > m_L + GAPC) begin
            m_busy = 1'b0; m_ready = 1'b1;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   initial forever begin
      @(negedge clk_in);
      if (run_chk) begin
         chk("code", code, m_code);
         chk("busy", busy, m_busy);
         chk("done", done, m_done);
         chk("tx_ready", tx_ready, m_ready);
      end
      if (busy === 1'b1 && !prev_b) d_acc++;
      prev_b = (busy === 1'b1);
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus helpers ----------------
   task automatic wait_ready();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk_in);
         #1;
         if (tx_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      chk("wait_ready", ok, 1);
   endtask

   // Send one frame; capture code mid-half-bit, the done cycle and the busy length.
   task automatic send_cap(input logic [10:0] d, input logic [3:0] l, input int nhb,
                           output logic [31:0] cap, output int done_c, output int busy_c);
      wait_ready();
      tx_data = d; tx_len = l; tx_valid = 1'b1;
      @(posedge clk_in);
      #1 tx_valid = 1'b0;
      cap = '0; done_c = -1; busy_c = 0;
      for (int c = 1; c <= 400; c++) begin
         @(negedge clk_in);
         if (((c - 2) % CLK_DIV) == 0 && ((c - 2) / CLK_DIV) < nhb) cap = {cap[30:0], code};
         if (done === 1'b1 && done_c < 0) done_c = c;
         if (busy === 1'b1) busy_c++;
         else break;
      end
   endtask

   logic [31:0] cap;
   int          dc, bc, cd, cs, acc0;
   bit          pb;

   initial begin
      #1 rst = 1'b0;
      #1 run_chk = 1'b1;
      repeat (3) @(negedge clk_in);
      chk("rst_code", code, 1);
      chk("rst_ready", tx_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      #2 rst = 1'b1;
      @(negedge clk_in);
      chk("ready_after_rst", tx_ready, 1);

      // Master request
      send_cap(11'h0A5, 4'd11, 28, cap, dc, bc);
      chk("t1_wave", cap, 32'h0AA66999);
      chk("t1_done_cycle", dc, 113);
      chk("t1_busy_len", bc, 112 + GAPC);

      // Slave response
      send_cap(11'b000_0000_1011, 4'd4, 14, cap, dc, bc);
      chk("t2_wave", cap, 32'h2655);
      chk("t2_done_cycle", dc, 57);
      chk("t2_busy_len", bc, 56 + GAPC);

      // Empty payload and clamped length
      send_cap(11'h7FF, 4'd0, 6, cap, dc, bc);
      chk("t4_len0_wave", cap, 32'h29);
      chk("t4_len0_done", dc, 25);
      chk("t4_len0_busy", bc, 24 + GAPC);
      send_cap(11'h0A5, 4'd15, 28, cap, dc, bc);
      chk("t4_len15_wave", cap, 32'h0AA66999);
      chk("t4_len15_done", dc, 113);

      // Back-to-back with tx_valid held
      wait_ready();
      acc0 = d_acc;
      tx_data = 11'h0A5; tx_len = 4'd11; tx_valid = 1'b1;
      @(posedge clk_in);
      #1 tx_data = 11'h3C6; tx_len = 4'd7;
      cd = -1; cs = -1; pb = 1'b1;
      for (int c = 1; c <= 400; c++) begin
         @(negedge clk_in);
         if (done === 1'b1 && cd < 0) cd = c;
         if (cd >= 0 && busy === 1'b1 && !pb) begin
            cs = c;
            break;
         end
         pb = (busy === 1'b1);
      end
      #1 tx_valid = 1'b0;
      chk("b2b_spacing", cs - cd, GAPC + 1);
      wait_ready();
      chk("b2b_accepts", d_acc - acc0, 2);

      // Reset at cycle 40 of a master frame (code low there for this payload)
      wait_ready();
      tx_data = 11'h325; tx_len = 4'd11; tx_valid = 1'b1;
      @(posedge clk_in);
      #1 tx_valid = 1'b0;
      repeat (39) @(posedge clk_in);
      #1 chk("t5_code_before", code, 0);
      rst = 1'b0;
      #1;
      chk("t5_code_async", code, 1);
      chk("t5_busy_async", busy, 0);
      chk("t5_done_async", done, 0);
      chk("t5_ready_async", tx_ready, 0);
      repeat (2) @(negedge clk_in);
      #2 rst = 1'b1;
      @(negedge clk_in);
      chk("t5_ready_after", tx_ready, 1);
      send_cap(11'h0A5, 4'd11, 28, cap, dc, bc);
      chk("t5_fresh_wave", cap, 32'h0AA66999);
      chk("t5_fresh_done", dc, 113);

      // Inputs toggling during a frame
      wait_ready();
      tx_data = 11'h5A3; tx_len = 4'd11; tx_valid = 1'b1;
      @(posedge clk_in);
      for (int c = 1; c <= 100; c++) begin
         @(negedge clk_in);
         chk("t6_ready_low", tx_ready, 0);
         #1;
         tx_valid = 1'($urandom);
         tx_data  = 11'($urandom);
         tx_len   = 4'($urandom);
      end
      tx_valid = 1'b0;

      // Random frames
      for (int k = 0; k < 12; k++) begin
         wait_ready();
         repeat ($urandom_range(0, 3)) @(negedge clk_in);
         tx_data = 11'($urandom); tx_len = 4'($urandom); tx_valid = 1'b1;
         @(posedge clk_in);
         #1 tx_valid = 1'b0;
      end
      wait_ready();
      repeat (5) @(negedge clk_in);
      run_chk = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
